regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_sb_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 65 ++++++
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and width helpers for the parametrised integer register file.
package regfile_pkg;

    localparam int DEF_XLEN     = 64;
    localparam int DEF_NREGS    = 32;
    localparam int DEF_NRD      = 2;
    localparam bit DEF_ZERO_REG = 1'b1;

    function automatic int addr_width_f(input int nregs);
        if (nregs < 2) begin
            return 1;
        end else begin
            return $clog2(nregs);
        end
    endfunction

    // Counter must be able to hold NREGS itself, hence the +1.
    function automatic int cnt_width_f(input int nregs);
        return $clog2(nregs + 1);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: read ports, writeback port, issue port and status.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = DEF_NRD
) ();

    localparam int AW = addr_width_f(NREGS);
    localparam int CW = cnt_width_f(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                issue_en;
    logic [AW-1:0]       issue_rd;
    logic [CW-1:0]       busy_cnt;
    logic                err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        input  rd_data, rd_busy, busy_cnt, err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        output rd_data, rd_busy, busy_cnt, err
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for in-flight destinations, exact busy population count
// and a sticky flag for issues that collide with an outstanding writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NREGS    = DEF_NREGS,
    parameter bit  ZERO_REG = DEF_ZERO_REG,
    localparam int AW       = addr_width_f(NREGS),
    localparam int CW       = cnt_width_f(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_legal,
    input  logic [AW-1:0]    wr_addr,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    output logic [NREGS-1:0] busy,
    output logic [CW-1:0]    busy_cnt,
    output logic             err
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             issue_eff_s;
    logic             same_reg_s;
    logic             set_inc_s;
    logic             clr_dec_s;
    logic             illegal_s;

    // Next busy vector, count delta and illegal-issue detection.
    always_comb begin
        issue_eff_s = issue_en && !(ZERO_REG && (issue_rd == {AW{1'b0}}));
        same_reg_s  = wr_legal && issue_eff_s && (wr_addr == issue_rd);
        // Issue and writeback on one register: issue wins and the bit never drops.
        set_inc_s   = issue_eff_s && !busy_q[issue_rd];
        clr_dec_s   = wr_legal && busy_q[wr_addr] && !same_reg_s;
        illegal_s   = issue_eff_s && busy_q[issue_rd] && !same_reg_s;
        busy_d      = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            busy_d[i] = (issue_eff_s && (issue_rd == AW'(i))) ||
                        (busy_q[i] && !(wr_legal && (wr_addr == AW'(i))));
        end
        cnt_d = cnt_q + CW'(set_inc_s) - CW'(clr_dec_s);
        err_d = err_q || illegal_s;
    end

    // Scoreboard state, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= {NREGS{1'b0}};
            cnt_q  <= {CW{1'b0}};
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;
    assign err      = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with same-cycle writeback bypass on every read port
// and a busy scoreboard for hazard detection at issue.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int  XLEN     = DEF_XLEN,
    parameter int  NREGS    = DEF_NREGS,
    parameter int  NRD      = DEF_NRD,
    parameter bit  ZERO_REG = DEF_ZERO_REG,
    localparam int AW       = addr_width_f(NREGS)
) (
    input logic         clk,
    input logic         reset,
    regfile_sb_if.slave bus
);

    logic [XLEN-1:0]     mem_q [NREGS];
    logic [XLEN-1:0]     mem_d [NREGS];
    logic                wr_legal_s;
    logic [NREGS-1:0]    busy_s;
    logic [AW-1:0]       ra_s;
    logic                hit_s;
    logic                zero_s;
    logic [NRD*XLEN-1:0] rd_data_s;
    logic [NRD-1:0]      rd_busy_s;

    // Writeback to storage; register 0 is never written when hardwired.
    always_comb begin
        wr_legal_s = bus.wr_en && !(ZERO_REG && (bus.wr_addr == {AW{1'b0}}));
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = (wr_legal_s && (bus.wr_addr == AW'(i))) ? bus.wr_data : mem_q[i];
        end
    end

    // Storage flops, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read muxes: reset and x0 force zero, a matching writeback is forwarded.
    always_comb begin
        rd_data_s = {(NRD*XLEN){1'b0}};
        rd_busy_s = {NRD{1'b0}};
        ra_s      = {AW{1'b0}};
        hit_s     = 1'b0;
        zero_s    = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            ra_s   = bus.rd_addr[p*AW +: AW];
            hit_s  = wr_legal_s && (bus.wr_addr == ra_s);
            zero_s = ZERO_REG && (ra_s == {AW{1'b0}});
            if (reset || zero_s) begin
                rd_data_s[p*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (hit_s) begin
                rd_data_s[p*XLEN +: XLEN] = bus.wr_data;
            end else begin
                rd_data_s[p*XLEN +: XLEN] = mem_q[ra_s];
            end
            rd_busy_s[p] = !reset && !zero_s && busy_s[ra_s] && !hit_s;
        end
    end

    assign bus.rd_data = rd_data_s;
    assign bus.rd_busy = rd_busy_s;

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_legal (wr_legal_s),
        .wr_addr  (bus.wr_addr),
        .issue_en (bus.issue_en),
        .issue_rd (bus.issue_rd),
        .busy     (busy_s),
        .busy_cnt (bus.busy_cnt),
        .err      (bus.err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb: default build, a ZERO_REG=0 build and a 3-port 32x16 build.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] exp_q [$];
    logic [63:0] exp_v;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(64), .NREGS(32), .NRD(2)) ifa ();
    regfile_sb_if #(.XLEN(64), .NREGS(32), .NRD(2)) ifb ();
    regfile_sb_if #(.XLEN(32), .NREGS(16), .NRD(3)) ifc ();

    regfile_sb #(.XLEN(64), .NREGS(32), .NRD(2), .ZERO_REG(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    regfile_sb #(.XLEN(64), .NREGS(32), .NRD(2), .ZERO_REG(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    regfile_sb #(.XLEN(32), .NREGS(16), .NRD(3), .ZERO_REG(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic idle_all();
        ifa.rd_addr = 10'd0; ifa.wr_en = 1'b0; ifa.wr_addr = 5'd0; ifa.wr_data = 64'd0;
        ifa.issue_en = 1'b0; ifa.issue_rd = 5'd0;
        ifb.rd_addr = 10'd0; ifb.wr_en = 1'b0; ifb.wr_addr = 5'd0; ifb.wr_data = 64'd0;
        ifb.issue_en = 1'b0; ifb.issue_rd = 5'd0;
        ifc.rd_addr = 12'd0; ifc.wr_en = 1'b0; ifc.wr_addr = 4'd0; ifc.wr_data = 32'd0;
        ifc.issue_en = 1'b0; ifc.issue_rd = 4'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        ifa.rd_addr = {5'd5, 5'd5};
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd5; ifa.wr_data = 64'h1234;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.busy_cnt !== exp_v) begin errors++; $display("FAIL reset_cnt: got %0d want %0d", ifa.busy_cnt, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.err !== exp_v[0]) begin errors++; $display("FAIL reset_err: got %b want %b", ifa.err, exp_v[0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_data[64 +: 64] !== exp_v) begin errors++; $display("FAIL reset_bypass_gated: got %h want %h", ifa.rd_data[64 +: 64], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_busy !== exp_v[1:0]) begin errors++; $display("FAIL reset_busy: got %b want %b", ifa.rd_busy, exp_v[1:0]); end
        @(negedge clk);
        idle_all();
        ifa.rd_addr = {5'd5, 5'd5};
        exp_q.push_back(64'd0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_data[0 +: 64] !== exp_v) begin errors++; $display("FAIL reset_no_store: got %h want %h", ifa.rd_data[0 +: 64], exp_v); end
        reset = 1'b0;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle_all();
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd7; ifa.wr_data = 64'hDEAD_BEEF;
        ifa.rd_addr = {5'd7, 5'd8};
        exp_q.push_back(64'hDEAD_BEEF); exp_q.push_back(64'd0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_data[64 +: 64] !== exp_v) begin errors++; $display("FAIL bypass_same_cycle: got %h want %h", ifa.rd_data[64 +: 64], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_data[0 +: 64] !== exp_v) begin errors++; $display("FAIL bypass_other_port: got %h want %h", ifa.rd_data[0 +: 64], exp_v); end
        @(negedge clk);
        ifa.wr_en = 1'b0;
        exp_q.push_back(64'hDEAD_BEEF);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_data[64 +: 64] !== exp_v) begin errors++; $display("FAIL bypass_stored: got %h want %h", ifa.rd_data[64 +: 64], exp_v); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        idle_all();
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd0; ifa.wr_data = 64'hFFFF; ifa.issue_en = 1'b1; ifa.issue_rd = 5'd0;
        ifb.wr_en = 1'b1; ifb.wr_addr = 5'd0; ifb.wr_data = 64'hFFFF; ifb.issue_en = 1'b1; ifb.issue_rd = 5'd0;
        exp_q.push_back(64'd0); exp_q.push_back(64'hFFFF);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_data[0 +: 64] !== exp_v) begin errors++; $display("FAIL x0_hardwired_bypass: got %h want %h", ifa.rd_data[0 +: 64], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifb.rd_data[0 +: 64] !== exp_v) begin errors++; $display("FAIL x0_plain_bypass: got %h want %h", ifb.rd_data[0 +: 64], exp_v); end
        @(negedge clk);
        idle_all();
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'hFFFF); exp_q.push_back(64'd1);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_data[0 +: 64] !== exp_v) begin errors++; $display("FAIL x0_hardwired_stored: got %h want %h", ifa.rd_data[0 +: 64], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.busy_cnt !== exp_v) begin errors++; $display("FAIL x0_issue_cnt: got %0d want %0d", ifa.busy_cnt, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifb.rd_data[0 +: 64] !== exp_v) begin errors++; $display("FAIL x0_plain_stored: got %h want %h", ifb.rd_data[0 +: 64], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifb.busy_cnt !== exp_v) begin errors++; $display("FAIL x0_plain_issue_cnt: got %0d want %0d", ifb.busy_cnt, exp_v); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle_all();
        ifa.issue_en = 1'b1; ifa.issue_rd = 5'd3;
        @(negedge clk);
        ifa.issue_rd = 5'd4;
        exp_q.push_back(64'd1);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.busy_cnt !== exp_v) begin errors++; $display("FAIL sb_cnt_first: got %0d want %0d", ifa.busy_cnt, exp_v); end
        @(negedge clk);
        idle_all();
        ifa.rd_addr = {5'd4, 5'd3};
        exp_q.push_back(64'd2); exp_q.push_back(64'd3);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.busy_cnt !== exp_v) begin errors++; $display("FAIL sb_cnt_second: got %0d want %0d", ifa.busy_cnt, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_busy !== exp_v[1:0]) begin errors++; $display("FAIL sb_rd_busy_set: got %b want %b", ifa.rd_busy, exp_v[1:0]); end
        @(negedge clk);
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = 64'h33;
        exp_q.push_back(64'd2); exp_q.push_back(64'd2);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_busy !== exp_v[1:0]) begin errors++; $display("FAIL sb_wb_clears_same_cycle: got %b want %b", ifa.rd_busy, exp_v[1:0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.busy_cnt !== exp_v) begin errors++; $display("FAIL sb_cnt_before_edge: got %0d want %0d", ifa.busy_cnt, exp_v); end
        @(negedge clk);
        ifa.wr_addr = 5'd4; ifa.wr_data = 64'h44;
        exp_q.push_back(64'd1);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.busy_cnt !== exp_v) begin errors++; $display("FAIL sb_cnt_after_wb: got %0d want %0d", ifa.busy_cnt, exp_v); end
        @(negedge clk);
        idle_all();
        exp_q.push_back(64'd0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.busy_cnt !== exp_v) begin errors++; $display("FAIL sb_cnt_drained: got %0d want %0d", ifa.busy_cnt, exp_v); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        idle_all();
        ifa.issue_en = 1'b1; ifa.issue_rd = 5'd9;
        @(negedge clk);
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd9; ifa.wr_data = 64'h99;
        @(negedge clk);
        ifa.wr_en = 1'b0;
        ifa.rd_addr = {5'd0, 5'd9};
        exp_q.push_back(64'd1); exp_q.push_back(64'd0); exp_q.push_back(64'd1);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.busy_cnt !== exp_v) begin errors++; $display("FAIL same_cnt: got %0d want %0d", ifa.busy_cnt, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.err !== exp_v[0]) begin errors++; $display("FAIL same_err: got %b want %b", ifa.err, exp_v[0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_busy[0] !== exp_v[0]) begin errors++; $display("FAIL same_still_busy: got %b want %b", ifa.rd_busy[0], exp_v[0]); end
        @(negedge clk);
        ifa.issue_en = 1'b0;
        exp_q.push_back(64'd1); exp_q.push_back(64'd1);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.err !== exp_v[0]) begin errors++; $display("FAIL waw_err_set: got %b want %b", ifa.err, exp_v[0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.busy_cnt !== exp_v) begin errors++; $display("FAIL waw_cnt: got %0d want %0d", ifa.busy_cnt, exp_v); end
        @(negedge clk);
        exp_q.push_back(64'd1);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.err !== exp_v[0]) begin errors++; $display("FAIL waw_err_sticky: got %b want %b", ifa.err, exp_v[0]); end
    endtask

    task automatic test_multi_port();
        @(negedge clk);
        idle_all();
        ifc.wr_en = 1'b1; ifc.wr_addr = 4'd1; ifc.wr_data = 32'h11;
        @(negedge clk);
        ifc.wr_addr = 4'd2; ifc.wr_data = 32'h22;
        @(negedge clk);
        ifc.wr_addr = 4'd15; ifc.wr_data = 32'hFF;
        ifc.rd_addr = {4'd15, 4'd2, 4'd1};
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(64'h11); exp_q.push_back(64'h22); exp_q.push_back(64'hFF);
            #1;
            for (int p = 0; p < 3; p++) begin
                exp_v = exp_q.pop_front(); checks++;
                if (ifc.rd_data[p*32 +: 32] !== exp_v[31:0]) begin
                    errors++; $display("FAIL multi_port%0d_pass%0d: got %h want %h", p, k, ifc.rd_data[p*32 +: 32], exp_v[31:0]);
                end
            end
            @(negedge clk);
            ifc.wr_en = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle_all();
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd5; ifa.wr_data = 64'h1234;
        ifa.issue_en = 1'b1; ifa.issue_rd = 5'd6;
        @(negedge clk);
        idle_all();
        ifa.rd_addr = {5'd6, 5'd5};
        exp_q.push_back(64'h1234); exp_q.push_back(64'd2);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_data[0 +: 64] !== exp_v) begin errors++; $display("FAIL mid_pre_data: got %h want %h", ifa.rd_data[0 +: 64], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.busy_cnt !== exp_v) begin errors++; $display("FAIL mid_pre_cnt: got %0d want %0d", ifa.busy_cnt, exp_v); end
        reset = 1'b1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_data[0 +: 64] !== exp_v) begin errors++; $display("FAIL mid_reset_data: got %h want %h", ifa.rd_data[0 +: 64], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.busy_cnt !== exp_v) begin errors++; $display("FAIL mid_reset_cnt: got %0d want %0d", ifa.busy_cnt, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.err !== exp_v[0]) begin errors++; $display("FAIL mid_reset_err: got %b want %b", ifa.err, exp_v[0]); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_data[0 +: 64] !== exp_v) begin errors++; $display("FAIL mid_post_data: got %h want %h", ifa.rd_data[0 +: 64], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (ifa.rd_busy[1] !== exp_v[0]) begin errors++; $display("FAIL mid_post_busy: got %b want %b", ifa.rd_busy[1], exp_v[0]); end
    endtask

    initial begin
        reset = 1'b1;
        idle_all();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_same_cycle();
        test_multi_port();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
